// File: rtl/count_sequencer.sv
// Run/pause/step sequencer for a mod-MOD display counter: divides the clock into
// an advance tick, steps through IDLE/RUN/PAUSE on button edges, drives HEX0.
module count_sequencer #(
  parameter int DIV = 25000000,
  parameter int MOD = 8,
  parameter int CW  = 3
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          step,
  input  logic          up,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          running,
  output logic          tick,
  output logic          wrap,
  output logic [6:0]    HEX0
);
  localparam int PW = $clog2(DIV);
  localparam logic [CW-1:0] TOP  = CW'(MOD - 1);
  localparam logic [PW-1:0] PTOP = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] count_q, count_d, adv_val;
  logic          tick_q, tick_d, wrap_q, wrap_d, running_q;
  logic [3:0]    hist_q;
  logic          start_e, stop_e, step_e, load_e, adv, adv_wrap;
  logic [3:0]    hex_idx;

  // history order {load, step, stop, start}; a held button acts once
  assign {load_e, step_e, stop_e, start_e} = {load, step, stop, start} & ~hist_q;

  always_comb begin
    adv_wrap = up ? (count_q == TOP) : (count_q == '0);
    if (up) adv_val = adv_wrap ? '0 : count_q + 1'b1;
    else    adv_val = adv_wrap ? TOP : count_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    adv     = 1'b0;
    if (load_e) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = (int'(load_val) >= MOD) ? TOP : load_val;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_e) begin
            state_d = RUN;
            presc_d = '0;
          end else adv = step_e;
        end
        RUN: begin
          // a stop freezes the prescaler even on its terminal cycle
          if (stop_e) state_d = PAUSE;
          else if (presc_q == PTOP) begin
            presc_d = '0;
            adv     = 1'b1;
          end else presc_d = presc_q + 1'b1;
        end
        PAUSE: begin
          if (stop_e) begin
            state_d = IDLE;
            presc_d = '0;
          end else if (start_e) state_d = RUN;
          else adv = step_e;
        end
        default: state_d = IDLE;
      endcase
    end
    if (adv) count_d = adv_val;
    tick_d = adv;
    wrap_d = adv & adv_wrap;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      hist_q    <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == RUN);
      hist_q    <= {load, step, stop, start};
    end
  end

  assign hex_idx = 4'(count_q);

  always_comb begin
    case (hex_idx)
      4'h0: HEX0 = 7'b1000000;
      4'h1: HEX0 = 7'b1111001;
      4'h2: HEX0 = 7'b0100100;
      4'h3: HEX0 = 7'b0110000;
      4'h4: HEX0 = 7'b0011001;
      4'h5: HEX0 = 7'b0010010;
      4'h6: HEX0 = 7'b0000010;
      4'h7: HEX0 = 7'b1111000;
      4'h8: HEX0 = 7'b0000000;
      4'h9: HEX0 = 7'b0010000;
      4'hA: HEX0 = 7'b0001000;
      4'hB: HEX0 = 7'b0000011;
      4'hC: HEX0 = 7'b1000110;
      4'hD: HEX0 = 7'b0100001;
      4'hE: HEX0 = 7'b0000110;
      default: HEX0 = 7'b0001110;
    endcase
  end

  assign count   = count_q;
  assign running = running_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed scenarios plus random buttons, checked each
// cycle against a rule-level model for a MOD=8 and a MOD=6 instance.
module tb_count_sequencer;
  localparam int DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    int st;
    int pre;
    int cnt;
    bit tick;
    bit wrap;
  } model_t;

  logic       clk, reset, start, stop, step, up, load;
  logic [2:0] load_val;
  logic [2:0] count, count6;
  logic       running, tick, wrap, running6, tick6, wrap6;
  logic [6:0] HEX0, hex6;

  int total = 0;
  int bad   = 0;
  model_t ma, mb;
  bit p_start, p_stop, p_step, p_load;

  count_sequencer #(.DIV(DIV), .MOD(8), .CW(3)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .up(up), .load(load), .load_val(load_val), .count(count),
    .running(running), .tick(tick), .wrap(wrap), .HEX0(HEX0));

  count_sequencer #(.DIV(DIV), .MOD(6), .CW(3)) dut6 (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .up(up), .load(load), .load_val(load_val), .count(count6),
    .running(running6), .tick(tick6), .wrap(wrap6), .HEX0(hex6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic model_t mreset();
    model_t m;
    m.st = S_IDLE; m.pre = 0; m.cnt = 0; m.tick = 0; m.wrap = 0;
    return m;
  endfunction

  // One clock edge of the rules: priority load > stop > start > step > terminal tick
  function automatic model_t mstep(model_t m, int mod, bit se, bit pe, bit ae,
                                   bit le, bit u, int lv);
    model_t n = m;
    bit go = 0;
    n.tick = 0; n.wrap = 0;
    if (le) begin
      n.st = S_IDLE; n.pre = 0; n.cnt = (lv >= mod) ? mod - 1 : lv;
    end else if (m.st == S_RUN) begin
      if (pe) n.st = S_PAUSE;
      else if (m.pre == DIV - 1) begin n.pre = 0; go = 1; end
      else n.pre = m.pre + 1;
    end else if (m.st == S_PAUSE) begin
      if (pe) begin n.st = S_IDLE; n.pre = 0; end
      else if (se) n.st = S_RUN;
      else go = ae;
    end else begin
      if (se) begin n.st = S_RUN; n.pre = 0; end
      else go = ae;
    end
    if (go) begin
      n.tick = 1;
      if (u) begin n.wrap = (m.cnt == mod - 1); n.cnt = (m.cnt + 1) % mod; end
      else   begin n.wrap = (m.cnt == 0);       n.cnt = (m.cnt + mod - 1) % mod; end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs set; advances one clock and checks.
  task automatic cyc();
    bit se, pe, ae, le;
    se = start & ~p_start; pe = stop & ~p_stop; ae = step & ~p_step; le = load & ~p_load;
    ma = mstep(ma, 8, se, pe, ae, le, up, int'(load_val));
    mb = mstep(mb, 6, se, pe, ae, le, up, int'(load_val));
    p_start = start; p_stop = stop; p_step = step; p_load = load;
    @(posedge clk); #1;
    chk("count",   count,   ma.cnt);
    chk("running", running, ma.st == S_RUN);
    chk("tick",    tick,    ma.tick);
    chk("wrap",    wrap,    ma.wrap);
    chk("hex",     HEX0,    SEG[ma.cnt]);
    chk("count6",  count6,  mb.cnt);
    chk("wrap6",   wrap6,   mb.wrap);
    @(negedge clk);
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; step = 0; up = 1; load = 0; load_val = 0;
    ma = mreset(); mb = mreset();
    p_start = 0; p_stop = 0; p_step = 0; p_load = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_running", running, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_hex", HEX0, 7'b1000000);
    reset = 0;

    // start, count up every DIV clocks
    start = 1; cyc(); start = 0;
    repeat (13) cyc();
    chk("run_count3", count, 3);
    chk("run_hex3", HEX0, 7'b0110000);

    // wrap up from 7, then wrap down from 0
    load_val = 7; load = 1; cyc(); load = 0;
    start = 1; cyc(); start = 0;
    repeat (4) cyc();
    up = 0;
    repeat (4) cyc();
    chk("down_wrap7", count, 7);

    // stop with prescaler at 2, hold paused, resume
    up = 1;
    for (int i = 0; i < 20 && !(ma.st == S_RUN && ma.pre == 2); i++) cyc();
    stop = 1; cyc(); stop = 0;
    repeat (20) cyc();
    start = 1; cyc(); start = 0;
    repeat (3) cyc();

    // step held in PAUSE gives one advance
    stop = 1; cyc(); stop = 0;
    step = 1; repeat (10) cyc(); step = 0;
    cyc();

    // load coincident with stop and terminal tick
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 20 && !(ma.st == S_RUN && ma.pre == DIV - 1); i++) cyc();
    load = 1; stop = 1; load_val = 5; cyc(); load = 0; stop = 0;
    chk("ld_count", count, 5);
    chk("ld_running", running, 0);
    chk("ld_tick", tick, 0);
    load_val = 7; load = 1; cyc(); load = 0;
    chk("clamp6", count6, 5);

    // async reset mid-RUN at count 4
    load_val = 4; load = 1; cyc(); load = 0;
    start = 1; cyc(); start = 0;
    repeat (2) cyc();
    #2 reset = 1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_running", running, 0);
    chk("arst_hex", HEX0, 7'b1000000);
    ma = mreset(); mb = mreset();
    p_start = 0; p_stop = 0; p_step = 0; p_load = 0;
    @(negedge clk); reset = 0;
    repeat (10) cyc();
    chk("arst_hold", count, 0);
    start = 1; cyc(); start = 0;
    repeat (4) cyc();
    chk("arst_restart", count, 1);

    // random button traffic
    repeat (400) begin
      start    = ($urandom_range(0, 5) == 0);
      stop     = ($urandom_range(0, 7) == 0);
      step     = ($urandom_range(0, 4) == 0);
      up       = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 25) == 0);
      load_val = 3'($urandom_range(0, 7));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
